pe_array_ctrl: RTL and testbench

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

---
 rtl/pe_array_ctrl.sv | 112 +++++++++++
 tb/tb_pe_array_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequences weight load, skewed X streaming and result drain for an NxN PE array
module pe_array_ctrl #(
    parameter int D_W = 16,
    parameter int N   = 4,
    parameter int K_W = 8,
    parameter int TMO = 64
) (
    input  logic                 I_CLK,
    input  logic                 I_RST,
    input  logic                 I_START,
    input  logic [K_W-1:0]       I_K_LEN,
    input  logic                 I_ABORT,
    input  logic                 I_ARR_RDY,
    input  logic                 I_OUT_VLD,
    output logic                 O_W_RD_EN,
    output logic [$clog2(N)-1:0] O_W_RD_ADDR,
    output logic                 O_X_RD_EN,
    output logic [K_W-1:0]       O_X_RD_ADDR,
    output logic [N-1:0]         O_ROW_VLD,
    output logic                 O_BUSY,
    output logic                 O_DONE,
    output logic                 O_ERR
);
    localparam int A_W = $clog2(N);
    localparam int T_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FIN} state_t;

    state_t         state, state_n;
    logic [A_W-1:0] w_cnt;
    logic [K_W-1:0] k_len, x_cnt, out_cnt;
    logic [T_W-1:0] drn_cnt;
    logic [N-1:0]   skew;
    logic           err_q;
    logic           kill, go, zero_err, out_hit, out_full, x_last, tmo_hit, x_en;
    logic [K_W:0]   out_sum;

    assign kill     = I_ABORT && state != IDLE;
    assign go       = state == IDLE && I_START && I_K_LEN != '0;
    assign zero_err = state == IDLE && I_START && I_K_LEN == '0;
    assign x_en     = state == STREAM && I_ARR_RDY;
    assign x_last   = x_cnt == k_len - 1'b1;
    assign out_hit  = I_OUT_VLD && (state == STREAM || state == DRAIN);
    assign out_sum  = {1'b0, out_cnt} + {{K_W{1'b0}}, out_hit};
    assign out_full = out_sum >= {1'b0, k_len};
    assign tmo_hit  = drn_cnt == T_W'(TMO - 1);

    // state register
    always_ff @(posedge I_CLK) begin
        if (I_RST)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next-state selection; abort overrides every other transition
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = go ? LOAD_W : IDLE;
            LOAD_W:  state_n = w_cnt == A_W'(N - 1) ? STREAM : LOAD_W;
            STREAM:  state_n = (x_en && x_last) ? DRAIN : STREAM;
            DRAIN:   state_n = (out_full || tmo_hit) ? FIN : DRAIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill)
            state_n = IDLE;
    end

    // outputs decoded from registered state; only I_ARR_RDY reaches an output combinationally
    always_comb begin
        O_W_RD_EN   = state == LOAD_W;
        O_W_RD_ADDR = w_cnt;
        O_X_RD_EN   = x_en;
        O_X_RD_ADDR = x_cnt;
        O_ROW_VLD   = skew;
        O_BUSY      = state != IDLE;
        O_DONE      = state == FIN;
        O_ERR       = err_q;
    end

    // counters, skew shift register and error pulse; abort clears everything like reset
    always_ff @(posedge I_CLK) begin
        if (I_RST || kill) begin
            k_len   <= '0;
            w_cnt   <= '0;
            x_cnt   <= '0;
            out_cnt <= '0;
            drn_cnt <= '0;
            skew    <= '0;
            err_q   <= 1'b0;
        end else begin
            skew    <= {skew[N-2:0], x_en};
            err_q   <= zero_err || (state == DRAIN && tmo_hit && !out_full);
            drn_cnt <= state == DRAIN ? drn_cnt + 1'b1 : '0;
            if (go) begin
                k_len   <= I_K_LEN;
                w_cnt   <= '0;
                x_cnt   <= '0;
                out_cnt <= '0;
            end else begin
                if (state == LOAD_W)
                    w_cnt <= w_cnt + 1'b1;
                if (x_en)
                    x_cnt <= x_cnt + 1'b1;
                if (!out_sum[K_W])
                    out_cnt <= out_sum[K_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: scoreboard bench for pe_array_ctrl with directed passes
module tb_pe_array_ctrl;
    localparam int N   = 4;
    localparam int K_W = 8;
    localparam int TMO = 64;
    localparam int A_W = $clog2(N);

    logic           I_CLK = 1'b0;
    logic           I_RST = 1'b1;
    logic           I_START = 1'b0;
    logic [K_W-1:0] I_K_LEN = '0;
    logic           I_ABORT = 1'b0;
    logic           I_ARR_RDY = 1'b1;
    logic           I_OUT_VLD = 1'b0;
    logic           O_W_RD_EN;
    logic [A_W-1:0] O_W_RD_ADDR;
    logic           O_X_RD_EN;
    logic [K_W-1:0] O_X_RD_ADDR;
    logic [N-1:0]   O_ROW_VLD;
    logic           O_BUSY, O_DONE, O_ERR;

    pe_array_ctrl #(.D_W(16), .N(N), .K_W(K_W), .TMO(TMO)) dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_START(I_START), .I_K_LEN(I_K_LEN),
        .I_ABORT(I_ABORT), .I_ARR_RDY(I_ARR_RDY), .I_OUT_VLD(I_OUT_VLD),
        .O_W_RD_EN(O_W_RD_EN), .O_W_RD_ADDR(O_W_RD_ADDR),
        .O_X_RD_EN(O_X_RD_EN), .O_X_RD_ADDR(O_X_RD_ADDR),
        .O_ROW_VLD(O_ROW_VLD), .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {int k; int c; int v;} ev_t;
    ev_t exq[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;

    always @(posedge I_CLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic void push(input int k, input int c, input int v);
        ev_t e;
        e.k = k;
        e.c = c;
        e.v = v;
        exq.push_back(e);
    endfunction

    function automatic void see(input int k, input int v, input string nm);
        int idx = -1;
        for (int i = 0; i < exq.size(); i++)
            if (exq[i].k == k) begin
                idx = i;
                break;
            end
        vectors++;
        if (idx < 0) begin
            miscompares++;
            $display("FAIL %s unexpected at cycle %0d value %0d", nm, cyc, v);
        end else begin
            if (exq[idx].c != cyc || exq[idx].v != v) begin
                miscompares++;
                $display("FAIL %s: got cycle %0d value %0d, expected cycle %0d value %0d",
                         nm, cyc, v, exq[idx].c, exq[idx].v);
            end
            exq.delete(idx);
        end
    endfunction

    // monitor: every presented output event is matched against the scoreboard
    always @(negedge I_CLK) begin
        if (mon_en) begin
            if (O_W_RD_EN) see(0, int'(O_W_RD_ADDR), "w_rd");
            if (O_X_RD_EN) see(1, int'(O_X_RD_ADDR), "x_rd");
            if (O_ROW_VLD != '0) see(2, int'(O_ROW_VLD), "row_vld");
            if (O_DONE) see(3, 0, "done");
            if (O_ERR) see(4, 0, "err");
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge I_CLK);
        #1;
    endtask

    task automatic exp_w(input int s, input int n);
        for (int a = 0; a < n; a++) push(0, s + 1 + a, a);
    endtask

    // X reads begin 5 cycles after start, skipping the stall cycle; row r echoes a read r+1 cycles later
    task automatic exp_x(input int s, input int k, input int stall, input int rlim);
        bit rm[0:511];
        int c = 5;
        for (int a = 0; a < k; a++) begin
            if (c == stall) c++;
            rm[c] = 1'b1;
            push(1, s + c, a);
            c++;
        end
        for (int t = 0; t < 512 && t <= rlim; t++) begin
            int v;
            v = 0;
            for (int r = 0; r < N; r++)
                if (t - r - 1 >= 0 && rm[t-r-1]) v |= (1 << r);
            if (v != 0) push(2, s + t, v);
        end
    endtask

    task automatic drive(input int k, input int len, input int stall, input int o_lo, input int o_hi,
                         input int abrt, input int rst_at, input int xs);
        I_START = 1'b1;
        I_K_LEN = K_W'(k);
        tick(1);
        for (int i = 1; i <= len; i++) begin
            if (i == 1) chk("busy_after_start", int'(O_BUSY), k != 0 ? 1 : 0);
            if ((abrt >= 0 && i == abrt + 1) || (rst_at >= 0 && i == rst_at + 1)) begin
                chk("row_vld_cleared", int'(O_ROW_VLD), 0);
                chk("busy_cleared", int'(O_BUSY), 0);
            end
            I_START   = (i == xs);
            I_K_LEN   = (i == xs) ? '0 : K_W'(k);
            I_ARR_RDY = (i != stall);
            I_OUT_VLD = (i == 2) || (i >= o_lo && i <= o_hi);
            I_ABORT   = (i == abrt);
            I_RST     = (i == rst_at);
            if (i == stall) begin
                #1;
                chk("x_en_stalled", int'(O_X_RD_EN), 0);
                chk("x_addr_held", int'(O_X_RD_ADDR), stall - 5);
            end
            tick(1);
        end
        I_START = 1'b0;
        I_ABORT = 1'b0;
        I_RST = 1'b0;
        I_OUT_VLD = 1'b0;
        I_ARR_RDY = 1'b1;
        I_K_LEN = '0;
        tick(2);
        chk("busy_idle", int'(O_BUSY), 0);
        chk("row_vld_idle", int'(O_ROW_VLD), 0);
        chk("pending_events", exq.size(), 0);
        exq.delete();
    endtask

    initial begin
        int s;
        tick(3);
        chk("rst_busy", int'(O_BUSY), 0);
        chk("rst_done", int'(O_DONE), 0);
        chk("rst_err", int'(O_ERR), 0);
        chk("rst_w_en", int'(O_W_RD_EN), 0);
        chk("rst_x_en", int'(O_X_RD_EN), 0);
        chk("rst_row_vld", int'(O_ROW_VLD), 0);
        I_RST = 1'b0;
        mon_en = 1'b1;
        tick(2);
        // nominal pass, start ignored while loading weights
        s = cyc;
        exp_w(s, 4);
        exp_x(s, 3, -1, 1000);
        push(3, s + 13, 0);
        drive(3, 16, -1, 10, 12, -1, -1, 3);
        // one stall cycle while streaming
        s = cyc;
        exp_w(s, 4);
        exp_x(s, 3, 6, 1000);
        push(3, s + 14, 0);
        drive(3, 17, 6, 11, 13, -1, -1, -1);
        // zero length request
        s = cyc;
        push(4, s + 1, 0);
        drive(0, 4, -1, 0, -1, -1, -1, -1);
        // drain timeout with a missing result, start ignored in drain
        s = cyc;
        exp_w(s, 4);
        exp_x(s, 3, -1, 1000);
        push(3, s + 72, 0);
        push(4, s + 72, 0);
        drive(3, 76, -1, 10, 11, -1, -1, 20);
        // abort while streaming, alongside a start
        s = cyc;
        exp_w(s, 4);
        exp_x(s, 2, -1, 6);
        drive(3, 8, -1, 0, -1, 6, -1, 6);
        // reset while loading weights
        s = cyc;
        exp_w(s, 2);
        drive(3, 6, -1, 0, -1, -1, 2, -1);
        // single row pass afterwards
        s = cyc;
        exp_w(s, 4);
        exp_x(s, 1, -1, 1000);
        push(3, s + 9, 0);
        drive(1, 11, -1, 8, 8, -1, -1, -1);
        // maximum length without wrap
        s = cyc;
        exp_w(s, 4);
        exp_x(s, 255, -1, 1000);
        push(3, s + 265, 0);
        drive(255, 268, -1, 10, 264, -1, -1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
